// File: rtl/seg14_msg_scheduler_if.sv
// seg14_msg_scheduler_if: valid/ready glyph write port between a message source and the scheduler
interface seg14_msg_scheduler_if #(parameter int MSG_LEN = 16, parameter int SEGW = 14);
  localparam int AW = $clog2(MSG_LEN);
  logic wr_valid;
  logic wr_ready;
  logic wr_commit;
  logic [AW-1:0] wr_addr;
  logic [SEGW-1:0] wr_data;
  modport master(output wr_valid, wr_addr, wr_data, wr_commit, input wr_ready);
  modport slave(input wr_valid, wr_addr, wr_data, wr_commit, output wr_ready);
endinterface

// File: rtl/seg14_msg_scheduler.sv
// seg14_msg_scheduler: multiplexed 14-segment scan with a double-buffered, optionally scrolling message
module seg14_msg_scheduler #(
  parameter int NDIG = 12,
  parameter int SEGW = 14,
  parameter int MSG_LEN = 16,
  parameter int DIV = 1000,
  parameter int SCROLL_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg14_msg_scheduler_if.slave    wr,
  input  logic                    scroll_en,
  input  logic                    blank,
  output logic [NDIG-1:0]         sel,
  output logic [SEGW-1:0]         segm,
  output logic                    frame_start,
  output logic                    swap_done
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int PW = $clog2(DIV);
  localparam int DW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int FW = SCROLL_FRAMES > 1 ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [AW:0] LEN = (AW+1)'(MSG_LEN);
  logic [PW-1:0] pre;
  logic [DW-1:0] digit;
  logic [AW-1:0] offset;
  logic [FW-1:0] frame_cnt;
  logic pending, tick, boundary, swap, step, wr_fire;
  logic [SEGW-1:0] active [MSG_LEN];
  logic [SEGW-1:0] shadow [MSG_LEN];
  logic [AW:0] sum;
  logic [AW-1:0] idx;
  assign tick = pre == PW'(DIV-1);
  assign boundary = tick && digit == DW'(NDIG-1);
  assign swap = boundary && pending;
  assign step = boundary && scroll_en && frame_cnt == FW'(SCROLL_FRAMES-1);
  assign wr.wr_ready = !pending;
  assign wr_fire = wr.wr_valid && !pending;
  assign frame_start = boundary;
  assign swap_done = swap;
  // offset and digit are both below MSG_LEN, so one conditional subtract wraps the sum
  assign sum = {1'b0, offset} + (AW+1)'(digit);
  assign idx = AW'(sum >= LEN ? sum - LEN : sum);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      digit <= '0;
      offset <= '0;
      frame_cnt <= '0;
      pending <= 1'b0;
      sel <= '0;
      segm <= '0;
      for (int i = 0; i < MSG_LEN; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) digit <= digit == DW'(NDIG-1) ? '0 : digit + 1'b1;
      sel <= NDIG'(1) << digit;
      segm <= blank ? '0 : active[idx];
      if (wr_fire && {1'b0, wr.wr_addr} < LEN) shadow[wr.wr_addr] <= wr.wr_data;
      pending <= swap ? 1'b0 : pending | (wr_fire && wr.wr_commit);
      // swap takes priority over a coinciding scroll step
      if (swap) begin
        active <= shadow;
        offset <= '0;
        frame_cnt <= '0;
      end else if (!scroll_en) frame_cnt <= '0;
      else if (boundary) begin
        frame_cnt <= step ? '0 : frame_cnt + 1'b1;
        if (step) offset <= offset == AW'(MSG_LEN-1) ? '0 : offset + 1'b1;
      end
    end
endmodule
